// File: rtl/bnn_feat_loader_if.sv
// Sample-ingest handshake and committed-frame bus between a sensor source,
// bnn_feat_loader and the downstream BNN classifier.
interface bnn_feat_loader_if #(
  parameter int unsigned FEAT_CNT  = 128,
  parameter int unsigned FEAT_BITS = 4,
  parameter int unsigned IN_BITS   = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic [IN_BITS-1:0]            in_data;
  logic                          in_last;
  logic [FEAT_CNT*FEAT_BITS-1:0] features;
  logic                          feat_valid;
  logic                          start;
  logic                          frame_err;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, features, feat_valid, start, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, features, feat_valid, start, frame_err
  );
endinterface

// File: rtl/bnn_feat_loader.sv
// Quantizes raw samples into a staged frame, commits it atomically to the feature bus
// and holds it for HOLD_CYCLES. Define BNN_FEAT_ROUND_EN for round-half-up quantization.
module bnn_feat_loader #(
  parameter int unsigned FEAT_CNT    = 128,
  parameter int unsigned FEAT_BITS   = 4,
  parameter int unsigned IN_BITS     = 8,
  parameter int unsigned HOLD_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  bnn_feat_loader_if.slave bus
);
  localparam int unsigned S     = IN_BITS - FEAT_BITS;
  localparam int unsigned FW    = FEAT_CNT * FEAT_BITS;
  localparam int unsigned CNT_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int unsigned HLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {LOAD, HOLD, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HLD_W-1:0]  hold_q, hold_d;
  logic [FW-1:0]     staging_q, staging_d;
  logic [FW-1:0]     features_q, features_d;
  logic              frame_err_q, frame_err_d;
  logic              drain_pend_q, drain_pend_d;
  logic              feat_valid_q, feat_valid_d;
  logic              start_q, start_d;

  logic [FEAT_BITS-1:0] q_val;
  logic                 accept;
  logic                 last_idx;
  logic                 commit;

`ifdef BNN_FEAT_ROUND_EN
  localparam logic [IN_BITS:0] HALF = {{IN_BITS{1'b0}}, 1'b1} << (S - 1);
  localparam logic [IN_BITS:0] SAT  = {{(S + 1){1'b0}}, {FEAT_BITS{1'b1}}};
  logic [IN_BITS:0] q_sum;
  logic [IN_BITS:0] q_shr;

  // One extra bit keeps the carry so a full-scale input saturates instead of wrapping.
  always_comb begin
    q_sum = {1'b0, bus.in_data} + HALF;
    q_shr = q_sum >> S;
    q_val = (q_shr > SAT) ? '1 : FEAT_BITS'(q_shr);
  end
`else
  assign q_val = FEAT_BITS'(bus.in_data >> S);
`endif

  assign bus.in_ready   = rst && (state_q != HOLD);
  assign bus.features   = features_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.feat_valid = feat_valid_q;
  assign bus.start      = start_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    staging_d    = staging_q;
    features_d   = features_q;
    frame_err_d  = frame_err_q;
    drain_pend_d = drain_pend_q;
    feat_valid_d = 1'b0;
    start_d      = 1'b0;
    accept       = bus.in_valid && bus.in_ready;
    last_idx     = (cnt_q == CNT_W'(FEAT_CNT - 1));
    commit       = 1'b0;

    case (state_q)
      LOAD: begin
        if (accept) begin
          commit = last_idx || bus.in_last;
          if (commit) begin
            // Publish staged slots plus the current beat; slots beyond it read as zero.
            for (int unsigned i = 0; i < FEAT_CNT; i++) begin
              if (CNT_W'(i) < cnt_q)
                features_d[i*FEAT_BITS +: FEAT_BITS] = staging_q[i*FEAT_BITS +: FEAT_BITS];
              else if (CNT_W'(i) == cnt_q)
                features_d[i*FEAT_BITS +: FEAT_BITS] = q_val;
              else
                features_d[i*FEAT_BITS +: FEAT_BITS] = '0;
            end
            staging_d    = '0;
            cnt_d        = '0;
            hold_d       = '0;
            frame_err_d  = !(last_idx && bus.in_last);
            drain_pend_d = last_idx && !bus.in_last;
            feat_valid_d = 1'b1;
            start_d      = 1'b1;
            state_d      = HOLD;
          end else begin
            staging_d[cnt_q*FEAT_BITS +: FEAT_BITS] = q_val;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (hold_q == HLD_W'(HOLD_CYCLES - 1)) begin
          state_d = drain_pend_q ? DRAIN : LOAD;
        end else begin
          hold_d       = hold_q + HLD_W'(1);
          feat_valid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (accept && bus.in_last) begin
          drain_pend_d = 1'b0;
          state_d      = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= LOAD;
      cnt_q        <= '0;
      hold_q       <= '0;
      staging_q    <= '0;
      features_q   <= '0;
      frame_err_q  <= 1'b0;
      drain_pend_q <= 1'b0;
      feat_valid_q <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      staging_q    <= staging_d;
      features_q   <= features_d;
      frame_err_q  <= frame_err_d;
      drain_pend_q <= drain_pend_d;
      feat_valid_q <= feat_valid_d;
      start_q      <= start_d;
    end
  end
endmodule

// File: tb/tb_bnn_feat_loader.sv
// Scoreboard bench for bnn_feat_loader: a behavioural model predicts every committed
// frame and the per-cycle start/feat_valid/in_ready pattern from the accepted beats.
module tb_bnn_feat_loader;
  localparam int unsigned FC = 4;
  localparam int unsigned FB = 4;
  localparam int unsigned IB = 8;
  localparam int unsigned HC = 3;

`ifdef BNN_FEAT_ROUND_EN
  localparam logic [15:0] EXP_EXACT = 16'hF210;
`else
  localparam logic [15:0] EXP_EXACT = 16'hF110;
`endif

  typedef struct packed {
    logic [15:0] f;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bnn_feat_loader_if #(.FEAT_CNT(FC), .FEAT_BITS(FB), .IN_BITS(IB)) bus ();

  bnn_feat_loader #(
    .FEAT_CNT(FC), .FEAT_BITS(FB), .IN_BITS(IB), .HOLD_CYCLES(HC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] qm(input logic [7:0] x);
`ifdef BNN_FEAT_ROUND_EN
    int unsigned v;
    v = (int'(x) + 8) / 16;
    return (v > 15) ? 4'hF : 4'(v);
`else
    return x[7:4];
`endif
  endfunction

  // Model state
  exp_t        sb[$];
  int unsigned start_cyc[$];
  exp_t        cur = '0;
  int unsigned m_cnt = 0;
  logic [15:0] m_stage = '0;
  logic        m_drain = 1'b0;
  logic        pend_start = 1'b0;
  int unsigned fv_left = 0;
  logic        m_ready;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    m_ready = rst && (fv_left == 0);
    check_eq("start", bus.start, pend_start);
    check_eq("feat_valid", bus.feat_valid, fv_left != 0);
    check_eq("in_ready", bus.in_ready, m_ready);
    if (pend_start) begin
      check_eq("sb_has_entry", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        cur = sb.pop_front();
        start_cyc.push_back(cyc);
      end
    end
    check_eq("features", bus.features, cur.f);
    check_eq("frame_err", bus.frame_err, cur.e);

    if (fv_left != 0) fv_left--;
    pend_start = 1'b0;
    if (!rst) begin
      sb.delete();
      cur     = '0;
      m_cnt   = 0;
      m_stage = '0;
      m_drain = 1'b0;
      fv_left = 0;
    end else if (m_ready && bus.in_valid) begin
      if (m_drain) begin
        if (bus.in_last) m_drain = 1'b0;
      end else begin
        m_stage[m_cnt*4 +: 4] = qm(bus.in_data);
        if (m_cnt == FC - 1 || bus.in_last) begin
          sb.push_back('{f: m_stage, e: !(m_cnt == FC - 1 && bus.in_last)});
          m_drain    = (m_cnt == FC - 1) && !bus.in_last;
          m_cnt      = 0;
          m_stage    = '0;
          pend_start = 1'b1;
          fv_left    = HC;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic last);
    int unsigned waits;
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    acc   = 1'b0;
    waits = 0;
    while (!acc && waits < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      waits++;
    end
    check_eq("accept_wait", acc, 1'b1);
  endtask

  task automatic settle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  logic [7:0] exact_s[4] = '{8'h00, 8'h17, 8'h18, 8'hFF};
  logic [7:0] long_s[6]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  int unsigned k0;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_features", bus.features, 16'h0);
    check_eq("rst_feat_valid", bus.feat_valid, 1'b0);
    check_eq("rst_start", bus.start, 1'b0);
    check_eq("rst_frame_err", bus.frame_err, 1'b0);
    check_eq("rst_in_ready", bus.in_ready, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("ready_after_rst", bus.in_ready, 1'b1);

    // Exact frame
    for (int i = 0; i < 4; i++) send_beat(exact_s[i], i == 3);
    settle();
    check_eq("exact_features", bus.features, EXP_EXACT);
    check_eq("exact_err", bus.frame_err, 1'b0);

    // Short frame
    send_beat(8'h40, 1'b0);
    send_beat(8'h80, 1'b1);
    settle();
    check_eq("short_features", bus.features, 16'h0084);
    check_eq("short_err", bus.frame_err, 1'b1);

    // Long frame, then an exact frame after the drain
    for (int i = 0; i < 6; i++) send_beat(long_s[i], i == 5);
    settle();
    check_eq("long_features", bus.features, 16'h4321);
    check_eq("long_err", bus.frame_err, 1'b1);
    send_beat(8'h50, 1'b0);
    send_beat(8'h60, 1'b0);
    send_beat(8'h70, 1'b0);
    send_beat(8'h80, 1'b1);
    settle();
    check_eq("after_long_features", bus.features, 16'h8765);
    check_eq("after_long_err", bus.frame_err, 1'b0);

    // Back-to-back frames with in_valid held high
    k0 = start_cyc.size();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 4; i++) send_beat(8'(16 * (f * 4 + i + 1)), i == 3);
    settle();
    check_eq("bp_start_count", start_cyc.size() - k0, 3);
    if (start_cyc.size() >= k0 + 3) begin
      check_eq("bp_period_1", start_cyc[k0+1] - start_cyc[k0], 7);
      check_eq("bp_period_2", start_cyc[k0+2] - start_cyc[k0+1], 7);
    end

    // Reset in the middle of a load
    send_beat(8'h20, 1'b0);
    send_beat(8'h30, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_features", bus.features, 16'h0);
    check_eq("midrst_frame_err", bus.frame_err, 1'b0);
    check_eq("midrst_feat_valid", bus.feat_valid, 1'b0);
    check_eq("midrst_start", bus.start, 1'b0);
    check_eq("midrst_in_ready", bus.in_ready, 1'b0);
    rst = 1'b1;
    send_beat(8'h90, 1'b0);
    send_beat(8'hA0, 1'b0);
    send_beat(8'hB0, 1'b0);
    send_beat(8'hC0, 1'b1);
    settle();
    check_eq("post_rst_idx0", bus.features[3:0], qm(8'h90));
    check_eq("post_rst_features", bus.features, 16'hCBA9);

    check_eq("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, failed=%0d", n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bnn_feat_loader.md
# bnn_feat_loader

Upstream feature-ingest stage for the sequential BNN classifiers (`romesh_seq` wrappers such as the gas-ID model). It accepts raw sensor samples one per handshake and quantizes each to `FEAT_BITS`. It assembles a complete `FEAT_CNT`-feature frame in a staging register, then commits the frame atomically to the classifier's parallel `features` bus. After committing, it holds the bus stable for a programmable number of cycles so the classifier can finish its computation.

## Interface
Parameters:
- `FEAT_CNT`, 128, features per frame.
- `FEAT_BITS`, 4, quantized feature width; must be less than `IN_BITS`.
- `IN_BITS`, 8, raw sample width.
- `HOLD_CYCLES`, 64, cycles the committed frame is held before the next load starts; must be at least 1.

Ports:
- `clk`, input, 1, single clock; everything is rising-edge.
- `rst`, input, 1, synchronous, active-low reset.
- `in_valid`, input, 1, sample offered.
- `in_ready`, output, 1, block accepts a sample this cycle.
- `in_data`, input, `IN_BITS`, raw unsigned sample.
- `in_last`, input, 1, marks the final sample of a frame.
- `features`, output, `FEAT_CNT*FEAT_BITS`, committed frame, connects to the classifier's `features` input.
- `feat_valid`, output, 1, high throughout HOLD.
- `start`, output, 1, one-cycle pulse on the first HOLD cycle.
- `frame_err`, output, 1, frame length was wrong; valid while `feat_valid` is high.

## Operation
- States: LOAD, HOLD, DRAIN.
- Reset:
  - state is LOAD; beat counter and hold counter are 0.
  - `features`, the staging register and `frame_err` are all-zero.
  - `feat_valid`, `start` and `in_ready` are 0; `in_ready` is forced 0 while `rst` is low.
- `in_ready` is 1 exactly in LOAD and DRAIN. A beat is accepted when `in_valid && in_ready`.
- LOAD:
  - An accepted beat writes `q(in_data)` to `staging[cnt*FEAT_BITS +: FEAT_BITS]`. The first beat of a frame goes to index 0. `cnt` then increments.
  - Commit happens on an accepted beat when `cnt==FEAT_CNT-1` or `in_last` is high.
  - On commit, `features` takes the staging contents including the current beat. Indices above the current one are forced to 0 in the same cycle.
  - On commit, `cnt` returns to 0, the staging register is cleared, and the state goes to HOLD.
- Error rules:
  - Short frame: `in_last` on beat `cnt<FEAT_CNT-1`. Set `frame_err=1`; unused features are 0.
  - Long frame: beat `FEAT_CNT-1` arrives without `in_last`. Set `frame_err=1` and set `drain_pend`.
  - Exact frame: `in_last` on beat `FEAT_CNT-1`. Set `frame_err=0`.
- HOLD:
  - `in_ready=0`, `feat_valid=1`; `start=1` only on the first HOLD cycle.
  - The hold counter counts `HOLD_CYCLES` cycles.
  - On the last HOLD cycle, the next state is DRAIN if `drain_pend`, otherwise LOAD.
- DRAIN: accepted beats are discarded. An accepted beat with `in_last` clears `drain_pend` and moves to LOAD.
- `features` changes only on a commit edge; it never shows a partially loaded frame. `frame_err` updates only on commit.
- Quantization `q(x)`, with `S = IN_BITS-FEAT_BITS`:
  - with rounding: `min((x + 2^(S-1)) >> S, 2^FEAT_BITS-1)`, computed in `IN_BITS+1` bits so that x = max saturates to all-ones;
  - without rounding: `x >> S`.
- Reset mid-operation, in any state, returns immediately to the reset values and discards any partial frame and `drain_pend`.

## Timing
- A sample accepted at edge N is committed, if it is the last, at edge N. `feat_valid` and `start` are high in cycle N+1.
- `feat_valid` stays high for exactly `HOLD_CYCLES` cycles, N+1 through N+HOLD_CYCLES. In cycle N+HOLD_CYCLES+1, `in_ready` is 1 when the next state is LOAD, and also when it is DRAIN.
- Minimum frame period is `FEAT_CNT+HOLD_CYCLES` cycles; throughput in LOAD is one sample per cycle.
- `in_valid` asserted during HOLD is ignored. The source must keep the sample and hold it until `in_ready`.
- `start` and `feat_valid` are registered outputs; no combinational path runs from `in_*` to any output except through the state.

## Configuration
- `BNN_FEAT_ROUND_EN` defined: round-half-up with saturation, as above.
- Undefined: pure truncation `x >> S`; no adder and no saturation logic.

## Test plan
Parameters for all cases: `FEAT_CNT=4`, `FEAT_BITS=4`, `IN_BITS=8`, `HOLD_CYCLES=3`.
- Exact frame, rounding enabled: samples 0x00, 0x17, 0x18, 0xFF with `in_last` on the fourth.
  - `features` = {F,2,1,0} (index 3 is the MSB nibble), `frame_err=0`.
  - `start` pulses one cycle after the last beat; `feat_valid` is high for 3 cycles.
- Same frame, macro undefined: `features` = {F,1,1,0}.
- Short frame: 0x40, 0x80 with `in_last` on the second → `features`={0,0,8,4}, `frame_err=1`, HOLD lasts 3 cycles.
- Long frame: six beats, `in_last` on the sixth.
  - Commit after beat 4 with `frame_err=1`, then HOLD for 3 cycles.
  - DRAIN then accepts and discards beats 5 and 6, then returns to LOAD.
  - The next exact frame gives `frame_err=0`.
- Backpressure: `in_valid` held high continuously.
  - `in_ready` is low for exactly the 3 HOLD cycles.
  - No beat is lost or duplicated across 3 back-to-back frames; frame period is 7 cycles.
- Reset mid-load: after 2 accepted beats, drive `rst=0` for 1 cycle.
  - All outputs return to reset values and the partial frame is gone.
  - The next 4-beat frame commits with index 0 equal to its own first sample.
